// File: rtl/reorder_buffer.sv
// Reorder buffer: dual allocate, dual writeback, in-order dual retire,
// precise exception flush and external redirect flush.
package rob_pkg;
  localparam int PKG_XLEN = 32;

  typedef struct packed {
    logic                is_valid;
    logic                is_ready;
    logic                has_exception;
    logic                is_store;
    logic [4:0]          rd;
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] result;
  } rob_entry_t;
endpackage

module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = 32,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int XLEN      = PKG_XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       rob_we,
  input  rob_entry_t       rob_entry0,
  input  rob_entry_t       rob_entry1,
  output logic [1:0]       rob_rdy,
  output logic [TAG_W-1:0] rob_tag0,
  output logic [TAG_W-1:0] rob_tag1,
  input  logic [1:0]       wb_valid,
  input  logic [TAG_W-1:0] wb_tag0,
  input  logic [TAG_W-1:0] wb_tag1,
  input  logic [XLEN-1:0]  wb_result0,
  input  logic [XLEN-1:0]  wb_result1,
  input  logic             wb_exc0,
  input  logic             wb_exc1,
  output logic [1:0]       commit_valid,
  output rob_entry_t       commit_entry0,
  output rob_entry_t       commit_entry1,
  output logic [TAG_W-1:0] commit_tag0,
  output logic [TAG_W-1:0] commit_tag1,
  input  logic             flush_in,
  output logic             exc_flush,
  output logic [XLEN-1:0]  exc_pc
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(ROB_DEPTH);
  localparam logic [TAG_W:0] ONE_C   = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] TWO_C   = (TAG_W+1)'(2);

  rob_entry_t       rob_q [ROB_DEPTH];
  rob_entry_t       rob_d [ROB_DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic [TAG_W-1:0] head1, tail1;
  logic [TAG_W:0]   free_w, n_alloc, n_commit;
  rob_entry_t       h0, h1;
  rob_entry_t       alloc0, alloc1;
  logic             c0, c1, exc;

  always_comb begin
    head1    = head_q + TAG_W'(1);
    tail1    = tail_q + TAG_W'(1);
    h0       = rob_q[head_q];
    h1       = rob_q[head1];
    free_w   = DEPTH_C - count_q;
    c0       = h0.is_valid & h0.is_ready
             & ~h0.has_exception;
    c1       = c0 & h1.is_valid & h1.is_ready
             & ~h1.has_exception
             & ~(h0.is_store & h1.is_store);
    exc      = h0.is_valid & h0.is_ready
             & h0.has_exception;
    n_alloc  = (TAG_W+1)'(rob_we[0])
             + (TAG_W+1)'(rob_we[1]);
    n_commit = (TAG_W+1)'(c0)
             + (TAG_W+1)'(c1);
  end

  // rob_rdy reflects pre-commit occupancy only
  always_comb begin
    unique case (1'b1)
      free_w >= TWO_C: rob_rdy = 2'b10;
      free_w == ONE_C: rob_rdy = 2'b01;
      default:         rob_rdy = 2'b00;
    endcase
    rob_tag0      = tail_q;
    rob_tag1      = tail1;
    commit_valid  = {c1, c0};
    commit_entry0 = h0;
    commit_entry1 = h1;
    commit_tag0   = head_q;
    commit_tag1   = head1;
    exc_flush     = exc;
    exc_pc        = exc ? h0.pc : '0;
  end

  always_comb begin
    rob_d = rob_q;
    if (wb_valid[0] && rob_q[wb_tag0].is_valid) begin
      rob_d[wb_tag0].is_ready      = 1'b1;
      rob_d[wb_tag0].result        = wb_result0;
      rob_d[wb_tag0].has_exception =
        rob_q[wb_tag0].has_exception | wb_exc0;
    end
    if (wb_valid[1] && rob_q[wb_tag1].is_valid) begin
      rob_d[wb_tag1].is_ready      = 1'b1;
      rob_d[wb_tag1].result        = wb_result1;
      rob_d[wb_tag1].has_exception =
        rob_q[wb_tag1].has_exception | wb_exc1;
    end
    if (c0) rob_d[head_q].is_valid = 1'b0;
    if (c1) rob_d[head1].is_valid  = 1'b0;

    alloc0               = rob_entry0;
    alloc0.is_valid      = 1'b1;
    alloc0.is_ready      = 1'b0;
    alloc0.has_exception = 1'b0;
    alloc1               = rob_entry1;
    alloc1.is_valid      = 1'b1;
    alloc1.is_ready      = 1'b0;
    alloc1.has_exception = 1'b0;

    unique case (rob_we)
      2'b11: begin
        rob_d[tail_q] = alloc0;
        rob_d[tail1]  = alloc1;
      end
      2'b01:   rob_d[tail_q] = alloc0;
      2'b10:   rob_d[tail_q] = alloc1;
      default: ;
    endcase

    head_d  = head_q + n_commit[TAG_W-1:0];
    tail_d  = tail_q + n_alloc[TAG_W-1:0];
    count_d = count_q + n_alloc - n_commit;

    if (flush_in || exc) begin
      for (int i = 0; i < ROB_DEPTH; i++)
        rob_d[i].is_valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++)
        rob_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rob_q   <= rob_d;
    end
  end

  a_alloc_fits: assert property (
    @(posedge clk) disable iff (!rst_n)
    n_alloc <= (TAG_W+1)'(rob_rdy));

  a_wb_distinct: assert property (
    @(posedge clk) disable iff (!rst_n)
    (&wb_valid) |-> (wb_tag0 != wb_tag1));

endmodule
